// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: scans DIGITS hex nibbles with a DIV-cycle slot,
// double-buffers new values so they are committed only at frame boundaries.
module seg_scan_display #(
  parameter int DIGITS     = 4,
  parameter int DIV        = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lzs,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  logic [CW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_v, act_v;
  logic [DIGITS-1:0]     pend_dp, act_dp;
  logic                  tick, commit;
  logic [DIGITS-1:0]     blank;
  logic [3:0]            nib;
  logic [6:0]            seg_on;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    commit = tick && (idx == IDX_LAST);
  end

  // NOTE: non-blocking assignments for every register so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
      pend_v  <= '0;
      pend_dp <= '0;
      act_v   <= '0;
      act_dp  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (load) begin
        pend_v  <= value;
        pend_dp <= dp_in;
      end
      // A load coinciding with the wrap bypasses the pending buffer.
      if (commit) begin
        act_v  <= load ? value : pend_v;
        act_dp <= load ? dp_in : pend_dp;
      end
    end
  end

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    blank   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (act_v[4*i +: 4] == 4'h0);
      if (i > 0)
        blank[i] = lzs && hi_zero;
    end
  end

  always_comb begin
    nib    = act_v[4*idx +: 4];
    seg_on = blank[idx] ? 7'h00 : hex7(nib);
  end

  // Polarity is applied here so reset drives the pins to "off" in either sense.
  always_ff @(posedge clk) begin
    if (reset) begin
      an    <= {DIGITS{INV}};
      seg   <= {7{INV}};
      dp    <= INV;
      frame <= 1'b0;
    end else begin
      an    <= (DIGITS'(1) << idx) ^ {DIGITS{INV}};
      seg   <= seg_on ^ {7{INV}};
      dp    <= act_dp[idx] ^ INV;
      frame <= commit;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: cycle-tagged expectations are queued by the
// stimulus and consumed by an independent negedge monitor.
module tb_seg_scan_display;

  localparam int R = 4;  // first edge with reset low

  logic clk = 1'b0;
  logic reset, reset_s, load, lzs;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [3:0] an_m;  logic [6:0] seg_m;  logic dp_m, fr_m;
  logic [0:0] an_1;  logic [6:0] seg_1;  logic dp_1, fr_1;
  logic [7:0] an_8;  logic [6:0] seg_8;  logic dp_8, fr_8;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  exp_t sb[$];
  logic [16:0] got, want;

  seg_scan_display #(.DIGITS(4), .DIV(4), .ACTIVE_LOW(1)) u_dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in), .lzs(lzs),
    .an(an_m), .seg(seg_m), .dp(dp_m), .frame(fr_m)
  );

  seg_scan_display #(.DIGITS(1), .DIV(1), .ACTIVE_LOW(1)) u_d1 (
    .clk(clk), .reset(reset_s), .load(1'b0), .value(4'h0), .dp_in(1'b0), .lzs(1'b0),
    .an(an_1), .seg(seg_1), .dp(dp_1), .frame(fr_1)
  );

  seg_scan_display #(.DIGITS(8), .DIV(3), .ACTIVE_LOW(1)) u_d8 (
    .clk(clk), .reset(reset_s), .load(1'b0), .value(32'h0), .dp_in(8'h00), .lzs(1'b0),
    .an(an_8), .seg(seg_8), .dp(dp_8), .frame(fr_8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [16:0] actual, input logic [16:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got an/seg/dp/frame=%h, expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].sel)
          0:       got = {4'h0, an_m, seg_m, dp_m, fr_m};
          1:       got = {7'h0, an_1, seg_1, dp_1, fr_1};
          default: got = {an_8, seg_8, dp_8, fr_8};
        endcase
        want = {sb[i].an, sb[i].seg, sb[i].dp, sb[i].fr};
        check($sformatf("dut%0d_cyc%0d", sb[i].sel, cyc), got, want);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        check($sformatf("missed_dut%0d_cyc%0d", sb[i].sel, sb[i].cyc), 17'h0, 17'h1FFFF);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int sel, input logic [7:0] a, input logic [6:0] s,
                      input logic d, input logic f);
    exp_t e;
    e = '{cyc: c, sel: sel, an: a, seg: s, dp: d, fr: f};
    sb.push_back(e);
  endtask

  // Main-DUT expectation at edge R+k.
  task automatic pm(input int k, input logic [3:0] a, input logic [6:0] s, input logic d,
                    input logic f);
    push(R + k, 0, {4'h0, a}, s, d, f);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a load so that it is sampled at edge R+k.
  task automatic ld(input int k, input logic [15:0] v, input logic [3:0] d);
    wait_cyc(R + k - 1);
    load  = 1'b1;
    value = v;
    dp_in = d;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_s = 1'b1; load = 1'b0; value = '0; dp_in = '0; lzs = 1'b0;

    // Reset state and free-running scan of 0000.
    push(2, 0, 8'h0F, 7'h7F, 1'b1, 1'b0);
    push(3, 0, 8'h0F, 7'h7F, 1'b1, 1'b0);
    pm(0,  4'hE, 7'h40, 1'b1, 1'b0);
    pm(4,  4'hD, 7'h40, 1'b1, 1'b0);
    pm(8,  4'hB, 7'h40, 1'b1, 1'b0);
    pm(12, 4'h7, 7'h40, 1'b1, 1'b0);
    pm(14, 4'h7, 7'h40, 1'b1, 1'b0);
    pm(15, 4'h7, 7'h40, 1'b1, 1'b1);
    pm(16, 4'hE, 7'h40, 1'b1, 1'b0);
    pm(31, 4'h7, 7'h40, 1'b1, 1'b1);

    // DIGITS=1, DIV=1: commit on every tick.
    push(2,     1, 8'h01, 7'h7F, 1'b1, 1'b0);
    push(R + 1, 1, 8'h00, 7'h40, 1'b1, 1'b1);
    push(R + 2, 1, 8'h00, 7'h40, 1'b1, 1'b1);
    push(R + 5, 1, 8'h00, 7'h40, 1'b1, 1'b1);

    // DIGITS=8, DIV=3: 24-cycle frame.
    push(3,      2, 8'hFF, 7'h7F, 1'b1, 1'b0);
    push(R + 0,  2, 8'hFE, 7'h40, 1'b1, 1'b0);
    push(R + 3,  2, 8'hFD, 7'h40, 1'b1, 1'b0);
    push(R + 21, 2, 8'h7F, 7'h40, 1'b1, 1'b0);
    push(R + 23, 2, 8'h7F, 7'h40, 1'b1, 1'b1);
    push(R + 24, 2, 8'hFE, 7'h40, 1'b1, 1'b0);
    push(R + 45, 2, 8'h7F, 7'h40, 1'b1, 1'b0);
    push(R + 47, 2, 8'h7F, 7'h40, 1'b1, 1'b1);

    wait_cyc(3);
    reset = 1'b0; reset_s = 1'b0;

    // Deferred load of 12AF at idx=1, visible only after the next commit.
    pm(24, 4'hB, 7'h40, 1'b1, 1'b0);
    pm(28, 4'h7, 7'h40, 1'b1, 1'b0);
    pm(30, 4'h7, 7'h40, 1'b1, 1'b0);
    pm(32, 4'hE, 7'h0E, 1'b1, 1'b0);
    pm(36, 4'hD, 7'h08, 1'b1, 1'b0);
    pm(40, 4'hB, 7'h24, 1'b1, 1'b0);
    pm(44, 4'h7, 7'h79, 1'b1, 1'b0);
    pm(47, 4'h7, 7'h79, 1'b1, 1'b1);
    ld(21, 16'h12AF, 4'b0000);

    // Leading-zero suppression of 0050, then of 0000.
    pm(48, 4'hE, 7'h40, 1'b1, 1'b0);
    pm(52, 4'hD, 7'h12, 1'b1, 1'b0);
    pm(56, 4'hB, 7'h7F, 1'b1, 1'b0);
    pm(60, 4'h7, 7'h7F, 1'b1, 1'b0);
    pm(64, 4'hE, 7'h40, 1'b1, 1'b0);
    pm(68, 4'hD, 7'h7F, 1'b1, 1'b0);
    pm(72, 4'hB, 7'h7F, 1'b1, 1'b0);
    pm(76, 4'h7, 7'h7F, 1'b1, 1'b0);
    pm(79, 4'h7, 7'h7F, 1'b1, 1'b1);
    wait_cyc(R + 39);
    lzs = 1'b1;
    ld(40, 16'h0050, 4'b0000);
    ld(56, 16'h0000, 4'b0000);

    // Load in the wrap cycle commits at once; a later load waits a full frame.
    pm(80,  4'hE, 7'h02, 1'b1, 1'b0);
    pm(84,  4'hD, 7'h12, 1'b1, 1'b0);
    pm(88,  4'hB, 7'h19, 1'b0, 1'b0);
    pm(89,  4'hB, 7'h19, 1'b0, 1'b0);
    pm(92,  4'h7, 7'h30, 1'b1, 1'b0);
    pm(95,  4'h7, 7'h30, 1'b1, 1'b1);
    pm(96,  4'hE, 7'h08, 1'b0, 1'b0);
    pm(100, 4'hD, 7'h10, 1'b1, 1'b0);
    pm(104, 4'hB, 7'h00, 1'b1, 1'b0);
    pm(108, 4'h7, 7'h78, 1'b1, 1'b0);
    ld(79, 16'h3456, 4'b0100);
    ld(81, 16'h789A, 4'b0001);

    // Reset with BEEF pending discards both buffers.
    pm(112, 4'hE, 7'h08, 1'b0, 1'b0);
    pm(116, 4'hF, 7'h7F, 1'b1, 1'b0);
    pm(117, 4'hF, 7'h7F, 1'b1, 1'b0);
    pm(118, 4'hE, 7'h40, 1'b1, 1'b0);
    pm(122, 4'hD, 7'h40, 1'b1, 1'b0);
    pm(126, 4'hB, 7'h40, 1'b1, 1'b0);
    pm(130, 4'h7, 7'h40, 1'b1, 1'b0);
    pm(133, 4'h7, 7'h40, 1'b1, 1'b1);
    pm(134, 4'hE, 7'h40, 1'b1, 1'b0);
    pm(138, 4'hD, 7'h40, 1'b1, 1'b0);
    ld(114, 16'hBEEF, 4'b1111);
    wait_cyc(R + 115);
    reset = 1'b1;
    lzs   = 1'b0;
    wait_cyc(R + 117);
    reset = 1'b0;

    wait_cyc(R + 141);
    while (sb.size() > 0) begin
      check($sformatf("unchecked_dut%0d_cyc%0d", sb[0].sel, sb[0].cyc), 17'h0, 17'h1FFFF);
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
